// File: rtl/bist_pkg.sv
// Shared types and x2-default constants for the benchmark BIST engine.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    localparam int              X2_PAT_W     = 10;
    localparam int              X2_RSP_W     = 7;
    localparam int              X2_SIG_W     = 16;
    localparam logic [9:0]      X2_LFSR_TAPS = 10'h240;
    localparam logic [9:0]      X2_LFSR_SEED = 10'h001;
    localparam logic [15:0]     X2_MISR_TAPS = 16'hB400;
    localparam logic [15:0]     X2_MISR_SEED = 16'h0000;

    localparam int              RSP_LAT_MAX  = 3;

    function automatic int max_rsp_lat();
        return RSP_LAT_MAX;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: load has priority over a compaction step.
module bist_misr
    import bist_pkg::*;
#(
    parameter int               SIG_W     = X2_SIG_W,
    parameter int               RSP_W     = X2_RSP_W,
    parameter logic [SIG_W-1:0] MISR_TAPS = X2_MISR_TAPS,
    parameter logic [SIG_W-1:0] MISR_SEED = X2_MISR_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [RSP_W-1:0] rsp,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_nxt;

    function automatic logic misr_fb(input logic [SIG_W-1:0] s);
        return ^(s & MISR_TAPS);
    endfunction

    // Next signature value for a tagged cycle.
    always_comb begin
        w_sig_nxt = {r_sig[SIG_W-2:0], misr_fb(r_sig)} ^ SIG_W'(rsp);
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= MISR_SEED;
        end else if (load) begin
            r_sig <= MISR_SEED;
        end else if (en) begin
            r_sig <= w_sig_nxt;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/bench_bist_engine.sv
// BIST engine: drives all-zero then a maximal LFSR sequence onto a benchmark and
// compacts its responses (after RSP_LAT cycles) into a MISR signature.
module bench_bist_engine
    import bist_pkg::*;
#(
    parameter int               PAT_W     = X2_PAT_W,
    parameter int               RSP_W     = X2_RSP_W,
    parameter int               SIG_W     = X2_SIG_W,
    parameter logic [PAT_W-1:0] LFSR_TAPS = X2_LFSR_TAPS,
    parameter logic [PAT_W-1:0] LFSR_SEED = X2_LFSR_SEED,
    parameter logic [SIG_W-1:0] MISR_TAPS = X2_MISR_TAPS,
    parameter logic [SIG_W-1:0] MISR_SEED = X2_MISR_SEED,
    parameter int               RSP_LAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [PAT_W-1:0] pat_o,
    input  logic [RSP_W-1:0] rsp_i,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
);

    localparam logic [PAT_W:0] LAST_IDX  = {1'b0, {PAT_W{1'b1}}};
    localparam logic [PAT_W:0] DRAIN_END = LAST_IDX + (PAT_W+1)'(RSP_LAT);

    bist_state_e      r_state;
    bist_state_e      w_state_nxt;
    logic [PAT_W-1:0] r_lfsr;
    logic [PAT_W-1:0] r_pat;
    logic [PAT_W:0]   r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             w_run;
    logic             w_load;
    logic             w_advance;
    logic             w_cnt_inc;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_tag_out;
    logic             w_absorb;
    logic [SIG_W-1:0] w_sig;

    function automatic logic [PAT_W-1:0] lfsr_step(input logic [PAT_W-1:0] s);
        return {s[PAT_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides everything, including start.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) w_state_nxt = ST_RUN;
                    else       w_state_nxt = ST_IDLE;
                end
                ST_RUN: begin
                    if (r_cnt == LAST_IDX) w_state_nxt = (RSP_LAT == 0) ? ST_DONE : ST_DRAIN;
                    else                   w_state_nxt = ST_RUN;
                end
                ST_DRAIN: begin
                    if (r_cnt == DRAIN_END) w_state_nxt = ST_DONE;
                    else                    w_state_nxt = ST_DRAIN;
                end
                ST_DONE: begin
                    if (start) w_state_nxt = ST_RUN;
                    else       w_state_nxt = ST_DONE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Control decode for the datapath and the next registered outputs.
    always_comb begin
        w_run     = (r_state == ST_RUN);
        w_load    = 1'b0;
        w_advance = 1'b0;
        w_cnt_inc = 1'b0;
        if (abort) begin
            w_load    = 1'b0;
            w_advance = 1'b0;
            w_cnt_inc = 1'b0;
        end else begin
            w_load    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
            w_advance = w_run && (r_cnt != LAST_IDX);
            w_cnt_inc = w_run || (r_state == ST_DRAIN);
        end
        w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // Pattern source: r_lfsr always holds the pattern to be driven next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
            r_pat  <= '0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_lfsr <= LFSR_SEED;
            r_pat  <= '0;
            r_cnt  <= '0;
        end else if (abort) begin
            r_pat  <= '0;
        end else begin
            if (w_advance) begin
                r_pat  <= r_lfsr;
                r_lfsr <= lfsr_step(r_lfsr);
            end
            if (w_cnt_inc) begin
                r_cnt <= r_cnt + {{PAT_W{1'b0}}, 1'b1};
            end
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    generate
        if (RSP_LAT == 0) begin : g_no_lat
            assign w_tag_out = w_run;
        end else begin : g_lat
            logic [RSP_LAT-1:0] r_tag;

            // Valid-tag delay line aligning the MISR with the delayed responses.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag <= '0;
                end else if (abort) begin
                    r_tag <= '0;
                end else begin
                    r_tag[0] <= w_run;
                    for (int i = 1; i < RSP_LAT; i++) begin
                        r_tag[i] <= r_tag[i-1];
                    end
                end
            end

            assign w_tag_out = r_tag[RSP_LAT-1];
        end
    endgenerate

    // A response arriving on the abort edge belongs to a cancelled run and is dropped.
    assign w_absorb = w_tag_out & ~abort;

    bist_misr #(
        .SIG_W     (SIG_W),
        .RSP_W     (RSP_W),
        .MISR_TAPS (MISR_TAPS),
        .MISR_SEED (MISR_SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_absorb),
        .load  (w_load),
        .rsp   (rsp_i),
        .sig   (w_sig)
    );

    assign pat_o     = r_pat;
    assign busy      = r_busy;
    assign done      = r_done;
    assign signature = w_sig;

endmodule

// File: tb/tb_bench_bist_engine.sv
// Self-checking bench for bench_bist_engine: default, 2-cycle-latency and 3-bit instances
// checked against a reference model of pattern order and signature compaction.
module tb_bench_bist_engine;

    localparam int N = 1024;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // default x2-sized instance
    logic        start_m, abort_m, busy_m, done_m;
    logic [9:0]  pat_m;
    logic [6:0]  rsp_m;
    logic [15:0] sig_m;
    int          mode;

    // RSP_LAT=2 instance with a two-stage registered loopback
    logic        start_l, abort_l, busy_l, done_l;
    logic [9:0]  pat_l;
    logic [6:0]  d1_l, d2_l;
    logic [15:0] sig_l;

    // 3-bit pattern instance
    logic        start_s, abort_s, busy_s, done_s;
    logic [2:0]  pat_s;
    logic [15:0] sig_s;

    logic [6:0]  tbl  [N];
    logic [9:0]  pats [N];
    logic [2:0]  seq_s [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bench_bist_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start_m), .abort(abort_m),
        .pat_o(pat_m), .rsp_i(rsp_m), .busy(busy_m), .done(done_m), .signature(sig_m)
    );

    bench_bist_engine #(.RSP_LAT(2)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(start_l), .abort(abort_l),
        .pat_o(pat_l), .rsp_i(d2_l), .busy(busy_l), .done(done_l), .signature(sig_l)
    );

    bench_bist_engine #(.PAT_W(3), .LFSR_TAPS(3'b110), .LFSR_SEED(3'b001)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s),
        .pat_o(pat_s), .rsp_i({4'b0000, pat_s}), .busy(busy_s), .done(done_s), .signature(sig_s)
    );

    always @(posedge clk) begin
        d1_l <= pat_l[6:0];
        d2_l <= d1_l;
    end

    // Behavioural stand-in for the x2 netlist.
    function automatic logic [6:0] x2f(input logic [9:0] p);
        logic [6:0] o;
        o[0] = (p[0] & p[1]) | p[9];
        o[1] = ^p[4:0];
        o[2] = p[2] ~^ p[7];
        o[3] = (p[3] | p[5]) & ~p[8];
        o[4] = p[6] ^ (p[1] & p[4]);
        o[5] = (&p[3:1]) | (p[0] ^ p[8]);
        o[6] = p[9] ? p[5] : p[2];
        return o;
    endfunction

    function automatic logic [6:0] resp_fn(input int md, input logic [9:0] p);
        case (md)
            1:       return x2f(p);
            2:       return x2f(p) ^ 7'h01;
            3:       return p[6:0];
            4:       return tbl[p];
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [15:0] misr_add(input logic [15:0] s, input logic [6:0] r);
        return {s[14:0], ^(s & 16'hB400)} ^ {9'h000, r};
    endfunction

    // Signature after absorbing the responses to the first n patterns.
    function automatic logic [15:0] sig_of(input int n, input int md);
        logic [15:0] s;
        s = 16'h0000;
        for (int k = 0; k < n; k++) s = misr_add(s, resp_fn(md, pats[k]));
        return s;
    endfunction

    always_comb rsp_m = resp_fn(mode, pat_m);

    task automatic run_main(input logic [15:0] exp_sig, input string name, input bit poke_start);
        int bad, first, poke;
        logic [9:0] fpat, fexp;
        logic fbusy, fdone;
        bad = 0; first = -1; fpat = 10'h000; fexp = 10'h000; fbusy = 1'b0; fdone = 1'b0;
        poke = poke_start ? int'($urandom_range(5, 1000)) : -1;
        @(negedge clk); start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        for (int c = 1; c <= N + 1; c++) begin
            start_m = (c == poke);
            if (c <= N) begin
                if (pat_m !== pats[c-1] || busy_m !== 1'b1 || done_m !== 1'b0) begin
                    bad++;
                    if (first < 0) begin first = c; fpat = pat_m; fexp = pats[c-1]; fbusy = busy_m; fdone = done_m; end
                end
                @(negedge clk);
            end else if (busy_m !== 1'b0 || done_m !== 1'b1) begin
                bad++;
                if (first < 0) begin first = c; fpat = pat_m; fexp = pat_m; fbusy = busy_m; fdone = done_m; end
            end
        end
        start_m = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_seq: %0d bad cycles, first cycle %0d pat_o=%h busy=%b done=%b, required pat_o=%h busy=%b done=%b",
                     name, bad, first, fpat, fbusy, fdone, fexp, (first <= N), (first > N));
        end
        checks++;
        if (sig_m !== exp_sig) begin
            failures++;
            $display("FAIL %s_sig: signature=%h required %h", name, sig_m, exp_sig);
        end
    endtask

    task automatic test_reset();
        checks++; if (pat_m !== 10'h000) begin failures++; $display("FAIL reset_pat: %h required 000", pat_m); end
        checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL reset_busy: %b required 0", busy_m); end
        checks++; if (done_m !== 1'b0) begin failures++; $display("FAIL reset_done: %b required 0", done_m); end
        checks++; if (sig_m !== 16'h0000) begin failures++; $display("FAIL reset_sig: %h required 0000", sig_m); end
        @(negedge clk); rst_n = 1'b1;
        mode = 1;
        @(negedge clk); start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pat_m !== 10'h000) begin failures++; $display("FAIL async_rst_pat: %h required 000", pat_m); end
        checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL async_rst_busy: %b required 0", busy_m); end
        checks++; if (done_m !== 1'b0) begin failures++; $display("FAIL async_rst_done: %b required 0", done_m); end
        checks++; if (sig_m !== 16'h0000) begin failures++; $display("FAIL async_rst_sig: %h required 0000", sig_m); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_m !== 1'b0 || done_m !== 1'b0 || pat_m !== 10'h000) begin
            failures++;
            $display("FAIL post_rst_idle: busy=%b done=%b pat_o=%h required 0 0 000", busy_m, done_m, pat_m);
        end
    endtask

    task automatic test_sequence();
        int bad, first;
        logic [15:0] exp_sig;
        bad = 0; first = -1;
        exp_sig = 16'h0000;
        for (int k = 0; k < 8; k++) exp_sig = misr_add(exp_sig, {4'b0000, seq_s[k]});
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (pat_s !== seq_s[c-1] || busy_s !== 1'b1 || done_s !== 1'b0) begin
                bad++;
                if (first < 0) first = c;
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL small_seq: %0d bad cycles, first cycle %0d pat_o=%b required %b",
                     bad, first, pat_s, seq_s[first-1]);
        end
        checks++;
        if (done_s !== 1'b1 || busy_s !== 1'b0) begin
            failures++;
            $display("FAIL small_done_c9: done=%b busy=%b required 1 0", done_s, busy_s);
        end
        checks++;
        if (sig_s !== exp_sig) begin failures++; $display("FAIL small_sig: %h required %h", sig_s, exp_sig); end
    endtask

    task automatic test_latency();
        int bad, first, busy_cnt, done_at;
        logic [15:0] exp_sig;
        bad = 0; first = -1; busy_cnt = 0; done_at = -1;
        exp_sig = sig_of(N, 3);
        @(negedge clk); start_l = 1'b1;
        @(negedge clk); start_l = 1'b0;
        for (int c = 1; c <= N + 3; c++) begin
            if (busy_l === 1'b1) busy_cnt++;
            if (done_l === 1'b1 && done_at < 0) done_at = c;
            if (c <= N && pat_l !== pats[c-1]) begin
                bad++;
                if (first < 0) first = c;
            end
            if (c < N + 3) @(negedge clk);
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL lat_seq: %0d bad cycles, first cycle %0d", bad, first); end
        checks++;
        if (done_at != N + 3) begin failures++; $display("FAIL lat_done_cycle: done first at %0d required %0d", done_at, N + 3); end
        checks++;
        if (busy_cnt != N + 2) begin failures++; $display("FAIL lat_busy_len: %0d cycles required %0d", busy_cnt, N + 2); end
        checks++;
        if (sig_l !== exp_sig) begin failures++; $display("FAIL lat_sig: %h required %h", sig_l, exp_sig); end
    endtask

    task automatic test_fault();
        logic [15:0] good;
        good = sig_of(N, 1);
        mode = 2;
        run_main(sig_of(N, 2), "fault", 1'b0);
        checks++;
        if (sig_m === good) begin failures++; $display("FAIL fault_detect: signature=%h must differ from %h", sig_m, good); end
    endtask

    task automatic test_random();
        for (int i = 0; i < N; i++) tbl[i] = 7'($urandom);
        mode = 4;
        run_main(sig_of(N, 4), "rand_start_poke", 1'b1);
    endtask

    task automatic test_done_controls();
        logic [15:0] exp_sig;
        exp_sig = sig_of(N, 4);
        repeat (4) @(negedge clk);
        checks++;
        if (done_m !== 1'b1 || sig_m !== exp_sig) begin
            failures++;
            $display("FAIL done_hold: done=%b sig=%h required 1 %h", done_m, sig_m, exp_sig);
        end
        start_m = 1'b1; abort_m = 1'b1;
        @(negedge clk); start_m = 1'b0; abort_m = 1'b0;
        checks++;
        if (done_m !== 1'b0 || busy_m !== 1'b0 || pat_m !== 10'h000) begin
            failures++;
            $display("FAIL start_abort_done: done=%b busy=%b pat_o=%h required 0 0 000", done_m, busy_m, pat_m);
        end
        checks++;
        if (sig_m !== exp_sig) begin failures++; $display("FAIL abort_keeps_sig: %h required %h", sig_m, exp_sig); end
        repeat (2) @(negedge clk);
        checks++;
        if (busy_m !== 1'b0) begin failures++; $display("FAIL idle_stays: busy=%b required 0", busy_m); end
    endtask

    task automatic test_abort();
        int a;
        logic [15:0] exp_sig;
        mode = 1;
        a = int'($urandom_range(1, 1000));
        exp_sig = sig_of(a - 1, 1);
        @(negedge clk); start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        repeat (a - 1) @(negedge clk);
        abort_m = 1'b1;
        @(negedge clk); abort_m = 1'b0;
        checks++;
        if (busy_m !== 1'b0 || done_m !== 1'b0 || pat_m !== 10'h000) begin
            failures++;
            $display("FAIL abort_idle: a=%0d busy=%b done=%b pat_o=%h required 0 0 000", a, busy_m, done_m, pat_m);
        end
        checks++;
        if (sig_m !== exp_sig) begin failures++; $display("FAIL abort_sig: a=%0d sig=%h required %h", a, sig_m, exp_sig); end
        repeat (3) @(negedge clk);
        checks++;
        if (sig_m !== exp_sig || busy_m !== 1'b0) begin
            failures++;
            $display("FAIL abort_settled: sig=%h busy=%b required %h 0", sig_m, busy_m, exp_sig);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] l;
        rst_n = 1'b0;
        start_m = 1'b0; abort_m = 1'b0;
        start_l = 1'b0; abort_l = 1'b0;
        start_s = 1'b0; abort_s = 1'b0;
        d1_l = 7'h00; d2_l = 7'h00;
        mode = 0;
        for (int i = 0; i < N; i++) tbl[i] = 7'h00;
        seq_s = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
        pats[0] = 10'h000;
        l = 10'h001;
        for (int k = 1; k < N; k++) begin
            pats[k] = l;
            l = {l[8:0], l[9] ^ l[6]};
        end
        #23;
        test_reset();
        test_sequence();
        mode = 0;
        run_main(16'h0000, "zero", 1'b0);
        mode = 1;
        run_main(sig_of(N, 1), "x2", 1'b0);
        test_fault();
        test_latency();
        test_random();
        test_done_controls();
        mode = 1;
        run_main(sig_of(N, 1), "x2_from_idle", 1'b0);
        run_main(sig_of(N, 1), "x2_rerun_done", 1'b0);
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bench_bist_engine.md
# bench_bist_engine

Self-test engine for the combinational mapped benchmarks, sized by default for the 10-input / 7-output `x2` netlist. It drives an exhaustive input pattern sequence onto the benchmark's primary inputs and compacts the returned primary outputs into a multiple-input signature register (MISR). The signature is compared against a golden value to qualify a mapped netlist after synthesis or mapping. It sits between a host or testbench control port and one benchmark instance.

## Interface
Parameters:
- `PAT_W`, 10: pattern width; the engine drives all 2^PAT_W patterns.
- `RSP_W`, 7: response width; must be ≤ `SIG_W`.
- `SIG_W`, 16: MISR width.
- `LFSR_TAPS`, 10'h240: feedback mask over the pattern LFSR (x^10+x^7+1); must be maximal-length.
- `LFSR_SEED`, 10'h001: LFSR start value; must be nonzero.
- `MISR_TAPS`, 16'hB400: MISR feedback mask (bits 15, 13, 12, 10).
- `MISR_SEED`, 16'h0000: MISR start value.
- `RSP_LAT`, 0: cycles from `pat_o` to the matching `rsp_i`; legal range 0..3.

Ports:
- `clk`, in, 1: the single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a run; sampled in IDLE or DONE.
- `abort`, in, 1: cancel a run; returns the engine to IDLE.
- `pat_o`, out, PAT_W: pattern to the benchmark inputs; registered.
- `rsp_i`, in, RSP_W: benchmark outputs.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: high in DONE.
- `signature`, out, SIG_W: MISR contents; stable while `done` is high.

## Operation
States:
- IDLE:
  - `pat_o`=0, `busy`=0, `done`=0.
  - `start` → RUN. On the same edge, LFSR←`LFSR_SEED`, MISR←`MISR_SEED`, count←0.
- RUN:
  - Pattern index 0 drives all-zero.
  - Indices 1..2^PAT_W−1 drive successive LFSR states, beginning with `LFSR_SEED`.
  - LFSR step: next = {lfsr[PAT_W-2:0], ^(lfsr & LFSR_TAPS)}.
  - After index 2^PAT_W−1 is driven: if `RSP_LAT`=0 → DONE, otherwise → DRAIN.
  - `start` is ignored.
- DRAIN:
  - Lasts `RSP_LAT` cycles.
  - `pat_o` holds the last pattern.
  - Compaction continues until the last response is absorbed, then → DONE.
- DONE:
  - `done`=1; `signature` frozen.
  - `start` → RUN, with the same reloads as from IDLE.
- `abort` in any state → IDLE. It clears `done` and `pat_o` and leaves `signature` at its current value. `abort` has priority over `start`.

Compaction:
- A valid tag shift register of depth `RSP_LAT` marks which cycles carry a response.
- On each tagged cycle, fb = ^(sig & MISR_TAPS) and sig ← {sig[SIG_W-2:0], fb} ^ zero-extend(rsp_i).
- Untagged cycles leave the MISR unchanged.

Widths: the pattern counter is PAT_W+1 bits and never wraps within a run.

Reset values: `pat_o`=0, `busy`=0, `done`=0, `signature`=`MISR_SEED`, state IDLE, tags cleared.

## Timing
- `start` sampled high at edge E0. Cycle 1 (after E0) shows `busy`=1 and `pat_o`=pattern 0.
- Pattern k is on `pat_o` in cycle 1+k.
- The response for pattern k is absorbed at the edge ending cycle 1+k+RSP_LAT.
- `done` rises in cycle 2^PAT_W+RSP_LAT+1. `busy` falls in the same cycle.
- Total run length: 2^PAT_W+RSP_LAT cycles of `busy`.
- `abort` sampled at edge Ea: `busy`=0 in the following cycle; in-flight responses are discarded.
- `rst_n` low mid-run: all outputs go to their reset values immediately, without waiting for `clk`.

## Structure
- `bist_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default tap and seed constants for the `x2` configuration;
  - a function giving the maximum legal `RSP_LAT`.
- Sub-module `bist_misr`: parameterised on `SIG_W`, `RSP_W`, `MISR_TAPS`, `MISR_SEED`, with ports `en`, `load`, `rsp`, `sig`.
- The LFSR, counter, tag pipeline and FSM live in the top module.

## Test plan
- Reset: assert `rst_n` low mid-RUN → `pat_o`=0, `busy`=0, `done`=0, `signature`=0 asynchronously. After release, state is IDLE.
- Sequence check, PAT_W=3, LFSR_TAPS=3'b110, LFSR_SEED=3'b001: `pat_o` over cycles 1..8 = 000, 001, 010, 101, 011, 111, 110, 100. `done` is high in cycle 9.
- Zero DUT: `rsp_i` tied 0, MISR_SEED=0, defaults → `signature`=16'h0000. `done` is high exactly 1025 cycles after the `start` edge.
- Latency: RSP_LAT=2, with a 2-stage registered copy of `pat_o[6:0]` fed back as `rsp_i` → `signature` equals the golden model for RSP_LAT=0 with the direct copy. `done` is high in cycle 1027.
- `x2` netlist attached, defaults → `signature` matches the behavioural-model golden value. Flipping one `x2` output (fault injection) changes `signature`.
- Control corners:
  - `start` pulsed during RUN → no restart.
  - `start` and `abort` together in DONE → IDLE.
  - `start` in DONE → new run with a signature identical to the first run.
